// File: rtl/gb_capture_pkg.sv
// Shared geometry and address helper for the Game Boy capture path and the
// framebuffer/VGA stages that consume its writes.
package gb_capture_pkg;

    localparam int unsigned GB_H_PIXELS = 160;
    localparam int unsigned GB_V_LINES  = 144;
    localparam int unsigned FB_ADDR_W   = 15;
    localparam int unsigned COORD_W     = 8;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;
    typedef logic [COORD_W-1:0]   coord_t;

    // Row-major address y*160+x built from shifts: 160 = 128 + 32.
    function automatic fb_addr_t gb_pixel_addr(input coord_t y, input coord_t x);
        fb_addr_t yz;
        fb_addr_t xz;
        yz = fb_addr_t'(y);
        xz = fb_addr_t'(x);
        return (yz << 7) + (yz << 5) + xz;
    endfunction

endpackage

// File: rtl/gb_sig_filter.sv
// Majority-free deglitcher: the filtered state only changes once FILTER_LEN
// consecutive raw samples agree. Transitions that complete while the history
// is still being refilled after reset are silent (state moves, no pulse).
// FILTER_LEN is expected to be at least 2.
module gb_sig_filter
#(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic state,
    output logic rise,
    output logic fall
);

    localparam int unsigned HIST_W = (FILTER_LEN > 1) ? FILTER_LEN - 1 : 1;
    localparam int unsigned CNT_W  = $clog2(FILTER_LEN + 1);

    logic [HIST_W-1:0] hist;
    logic [CNT_W-1:0]  fill_cnt;
    logic              armed;
    logic              go_high;
    logic              go_low;

    assign armed   = (fill_cnt == CNT_W'(FILTER_LEN));
    assign go_high = raw & (&hist) & ~state;
    assign go_low  = ~raw & ~(|hist) & state;
    assign rise    = go_high & armed;
    assign fall    = go_low & armed;

    // Sample history, filtered state and post-reset settling counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist     <= '0;
            state    <= 1'b0;
            fill_cnt <= '0;
        end else begin
            hist[0] <= raw;
            for (int unsigned i = 1; i < HIST_W; i++) begin
                hist[i] <= hist[i-1];
            end
            if (go_high) begin
                state <= 1'b1;
            end else if (go_low) begin
                state <= 1'b0;
            end
            if (!armed) begin
                fill_cnt <= fill_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gb_lcd_capture.sv
// Game Boy LCD bus capture: deglitches the sync/clock lines, realigns pixel
// data to the shift-clock edge and emits one framebuffer write per pixel.
module gb_lcd_capture
    import gb_capture_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned DATA_DELAY     = 5,
    parameter int unsigned H_PIXELS       = GB_H_PIXELS,
    parameter int unsigned V_LINES        = GB_V_LINES,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           idata,
    input  logic                 iclk,
    input  logic                 ihsync,
    input  logic                 ivsync,
    output logic                 wr_en,
    output logic [FB_ADDR_W-1:0] wr_addr,
    output logic [1:0]           wr_data,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic                 line_err,
    output logic                 signal_lost
);

    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam coord_t      X_SAT  = coord_t'(H_PIXELS);
    localparam coord_t      Y_SAT  = coord_t'(V_LINES);
    localparam coord_t      X_LAST = coord_t'(H_PIXELS - 1);
    localparam coord_t      Y_LAST = coord_t'(V_LINES - 1);

    logic ck_state, ck_rise, ck_fall;
    logic hs_state, hs_rise, hs_fall;
    logic vs_state, vs_rise, vs_fall;

    logic [1:0]       dly [DATA_DELAY];
    logic [1:0]       tap;
    coord_t           x;
    coord_t           y;
    logic             first_line;
    logic [TMR_W-1:0] timer;

    logic   ev_a;
    logic   ev_b;
    coord_t ev_x;
    coord_t ev_y;
    coord_t nxt_x;
    coord_t nxt_y;
    logic   nxt_first;
    logic   in_range;

    gb_sig_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk   (clk),
        .rst   (rst),
        .raw   (iclk),
        .state (ck_state),
        .rise  (ck_rise),
        .fall  (ck_fall)
    );

    gb_sig_filter #(.FILTER_LEN(FILTER_LEN)) u_hs_filt (
        .clk   (clk),
        .rst   (rst),
        .raw   (ihsync),
        .state (hs_state),
        .rise  (hs_rise),
        .fall  (hs_fall)
    );

    gb_sig_filter #(.FILTER_LEN(FILTER_LEN)) u_vs_filt (
        .clk   (clk),
        .rst   (rst),
        .raw   (ivsync),
        .state (vs_state),
        .rise  (vs_rise),
        .fall  (vs_fall)
    );

    // Pixel data ages alongside the filter latency so the tap lines up with
    // the raw clock edge rather than the filtered one.
    assign tap = dly[DATA_DELAY-1];

    // Idata delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DATA_DELAY; i++) begin
                dly[i] <= 2'b00;
            end
        end else begin
            dly[0] <= idata;
            for (int unsigned i = 1; i < DATA_DELAY; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    // Decode this cycle's pixel event and the coordinates it lands on.
    always_comb begin
        ev_a      = hs_fall;
        // A line start wins over a coincident shift-clock edge.
        ev_b      = ck_fall & ~hs_state & ~hs_fall;
        ev_x      = x;
        ev_y      = y;
        nxt_x     = x;
        nxt_y     = y;
        nxt_first = first_line;
        if (ev_a) begin
            ev_x = '0;
            if (!first_line) begin
                ev_y = (y >= Y_SAT) ? y : y + coord_t'(1);
            end
            nxt_y     = ev_y;
            nxt_first = 1'b0;
            nxt_x     = coord_t'(1);
        end else if (ev_b) begin
            nxt_x = (x >= X_SAT) ? x : x + coord_t'(1);
        end
        in_range = (ev_x < X_SAT) && (ev_y < Y_SAT);
    end

    // Position counters, timeout and registered write/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            x           <= '0;
            y           <= '0;
            first_line  <= 1'b1;
            timer       <= TMR_W'(TIMEOUT_CYCLES);
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= 2'b00;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= 2'b00;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
            if (vs_rise) begin
                // Frame boundary swallows any pixel event in the same cycle.
                x           <= '0;
                y           <= '0;
                first_line  <= 1'b1;
                frame_start <= 1'b1;
                timer       <= TMR_W'(TIMEOUT_CYCLES);
                signal_lost <= 1'b0;
            end else begin
                if (ev_a || ev_b) begin
                    x          <= nxt_x;
                    y          <= nxt_y;
                    first_line <= nxt_first;
                    if (in_range) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= gb_pixel_addr(ev_y, ev_x);
                        wr_data    <= ~tap;
                        frame_done <= (ev_y == Y_LAST) && (ev_x == X_LAST);
                    end else begin
                        line_err <= 1'b1;
                    end
                end
                if (timer != '0) begin
                    timer <= timer - TMR_W'(1);
                    if (timer == TMR_W'(1)) begin
                        signal_lost <= 1'b1;
                    end
                end else begin
                    signal_lost <= 1'b1;
                end
            end
        end
    end

endmodule
